// File: rtl/viol_reset_seq_if.sv
// Bus between the security monitors / reset handler and the violation reset
// sequencer. The master side raises reset requests and clears the cause
// register. The slave side (the sequencer) reports reset state and history.
interface viol_reset_seq_if #(
  parameter int N_SRC = 4,
  parameter int CNT_W = 8
);
  logic [N_SRC-1:0] viol_req;
  logic             cause_clr;
  logic             sys_rst;
  logic [N_SRC-1:0] viol_cause;
  logic [CNT_W-1:0] viol_count;
  logic             busy;

  modport master (
    output viol_req, cause_clr,
    input  sys_rst, viol_cause, viol_count, busy
  );

  modport slave (
    input  viol_req, cause_clr,
    output sys_rst, viol_cause, viol_count, busy
  );
endinterface

// File: rtl/viol_reset_seq.sv
// Violation reset sequencer.
// Merges the reset requests from the hardware security monitors into one
// registered PUC reset for the MSP430 core. The reset is held for a guaranteed
// minimum width, and stays asserted while any monitor still requests it.
// Which monitors fired is kept in a sticky cause register, and the number of
// distinct violation events is kept in a saturating counter. The reset
// handler reads both after the core comes out of reset.
module viol_reset_seq #(
  parameter int N_SRC      = 4,
  parameter int RST_CYCLES = 8,
  parameter int CNT_W      = 8
) (
  input logic             clk,
  input logic             reset_n,
  viol_reset_seq_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ASSERT = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  localparam logic [7:0]       TIMER_INIT = 8'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [1:0]       state;
  logic [7:0]       timer;
  logic             sys_rst_q;
  logic [N_SRC-1:0] cause_q;
  logic [CNT_W-1:0] count_q;
  logic             any_req;

  assign any_req = |bus.viol_req;

  // Reset sequencing FSM. Out of reset_n the FSM starts in HOLD, so the core
  // cannot start running while a monitor is still requesting reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HOLD;
      timer     <= 8'd0;
      sys_rst_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ASSERT;
            timer     <= TIMER_INIT;
            sys_rst_q <= 1'b1;
          end else begin
            sys_rst_q <= 1'b0;
          end
        end
        ASSERT: begin
          if (timer == 8'd0) begin
            if (any_req) begin
              state     <= HOLD;
              sys_rst_q <= 1'b1;
            end else begin
              state     <= IDLE;
              sys_rst_q <= 1'b0;
            end
          end else begin
            timer     <= timer - 8'd1;
            sys_rst_q <= 1'b1;
          end
        end
        HOLD: begin
          if (!any_req) begin
            state     <= IDLE;
            sys_rst_q <= 1'b0;
          end else begin
            sys_rst_q <= 1'b1;
          end
        end
        default: begin
          state     <= HOLD;
          sys_rst_q <= 1'b1;
        end
      endcase
    end
  end

  // Sticky cause record. A request in the same cycle as a clear wins, so the
  // clear can never hide a new violation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_q <= '0;
    end else if (bus.cause_clr && (state == IDLE)) begin
      cause_q <= bus.viol_req;
    end else begin
      cause_q <= cause_q | bus.viol_req;
    end
  end

  // Event counter. Only an IDLE->ASSERT entry is a new event. It saturates
  // rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if ((state == IDLE) && any_req && (count_q != CNT_MAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign bus.sys_rst    = sys_rst_q;
  assign bus.viol_cause = cause_q;
  assign bus.viol_count = count_q;
  assign bus.busy       = (state != IDLE);

endmodule
